// File: rtl/uart_tx_serializer.sv
// UART frame transmitter: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit.
// Every output is a register, so the serial line never glitches on state changes.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_available,
    output logic                 tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par, par_n;
    logic                 tx_n, avail_n, done_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            tx           <= 1'b1;
            tx_available <= 1'b1;
            tx_done      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_n;
            shreg        <= sh_n;
            par          <= par_n;
            tx           <= tx_n;
            tx_available <= avail_n;
            tx_done      <= done_n;
        end
    end

    // Next-state logic also computes the level tx must show during the next bit,
    // so that tx can be registered without a cycle of lag.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        par_n   = par;
        tx_n    = tx;
        avail_n = 1'b0;
        done_n  = 1'b0;

        if (state == IDLE) begin
            tx_n    = 1'b1;
            avail_n = 1'b1;
            if (send) begin
                state_n = START;
                cnt_n   = '0;
                bit_n   = '0;
                sh_n    = data_in;
                par_n   = (^data_in) ^ (PARITY_ODD != 0);
                tx_n    = 1'b0;
                avail_n = 1'b0;
            end
        end else if (cnt != CNT_LAST) begin
            cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
            case (state)
                START: begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end
                DATA: begin
                    if (bit_idx == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_idx + 1'b1;
                        sh_n  = shreg >> 1;
                        tx_n  = shreg[1];
                    end
                end
                PARITY: begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
                STOP: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    avail_n = 1'b1;
                    done_n  = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    avail_n = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four transmitter configurations checked cycle by cycle
// against a slot-based model of the UART frame.
module tb_uart_tx_serializer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] send_v = '0;
    logic [7:0] data_in = '0;
    logic [3:0] tx_v, av_v, dn_v;

    int n_checks = 0;
    int n_pass   = 0;

    logic otx [0:8999];
    logic oav [0:8999];
    logic odn [0:8999];

    always #5 clock = ~clock;

    // 0: no parity, 1: even parity, 2: odd parity (all 4 clocks/bit), 3: defaults
    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) d0 (
        .clock(clock), .reset(reset), .send(send_v[0]), .data_in(data_in),
        .tx(tx_v[0]), .tx_available(av_v[0]), .tx_done(dn_v[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) d1 (
        .clock(clock), .reset(reset), .send(send_v[1]), .data_in(data_in),
        .tx(tx_v[1]), .tx_available(av_v[1]), .tx_done(dn_v[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) d2 (
        .clock(clock), .reset(reset), .send(send_v[2]), .data_in(data_in),
        .tx(tx_v[2]), .tx_available(av_v[2]), .tx_done(dn_v[2]));
    uart_tx_serializer d3 (
        .clock(clock), .reset(reset), .send(send_v[3]), .data_in(data_in),
        .tx(tx_v[3]), .tx_available(av_v[3]), .tx_done(dn_v[3]));

    // Line level j cycles after the acceptance edge: slot 0 start, 1..8 data LSB first,
    // slot 9 parity when enabled, then stop, then idle mark.
    function automatic logic exp_tx(int j, logic [7:0] b, int cpb, int pen, int podd);
        int slot;
        slot = j / cpb;
        if (j >= (10 + pen) * cpb) return 1'b1;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (pen != 0 && slot == 9) return (^b) ^ (podd != 0);
        return 1'b1;
    endfunction

    // Issue one send to instance d and record ncyc samples starting at the acceptance edge.
    // b1/b2: cycles at which an extra (ignored) send of 0xFF is pulsed; hold keeps send high.
    task automatic capture(input int d, input logic [7:0] b, input int ncyc,
                           input int b1, input int b2, input bit hold, input logic [7:0] b_next);
        send_v    = '0;
        send_v[d] = 1'b1;
        data_in   = b;
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clock); #1;
            otx[j] = tx_v[d];
            oav[j] = av_v[d];
            odn[j] = dn_v[d];
            if (hold) begin
                data_in = b_next;
            end else begin
                send_v[d] = (j + 1 == b1) || (j + 1 == b2);
                data_in   = send_v[d] ? 8'hFF : 8'($urandom);
            end
        end
        send_v = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if ({tx_v[d], av_v[d], dn_v[d]} !== 3'b110)
                $display("FAIL reset_state dut%0d: got tx/avail/done=%b required 110", d, {tx_v[d], av_v[d], dn_v[d]});
            else n_pass++;
        end
        // send together with reset: reset wins, nothing latched
        send_v = 4'b1111;
        data_in = 8'h00;
        @(posedge clock); #1;
        send_v = '0;
        reset = 1'b0;
        @(posedge clock); #1;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if ({tx_v[d], av_v[d], dn_v[d]} !== 3'b110)
                $display("FAIL reset_vs_send dut%0d: got tx/avail/done=%b required 110", d, {tx_v[d], av_v[d], dn_v[d]});
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [9:0] seq;
        seq = 10'b1101001010;
        capture(0, 8'hA5, 42, -1, -1, 1'b0, 8'h00);
        for (int j = 0; j < 42; j++) begin
            n_checks++;
            if (otx[j] !== exp_tx(j, 8'hA5, 4, 0, 0) || oav[j] !== (j >= 40) || odn[j] !== (j == 40))
                $display("FAIL basic_frame j=%0d: got tx/avail/done=%b%b%b required %b%b%b", j,
                         otx[j], oav[j], odn[j], exp_tx(j, 8'hA5, 4, 0, 0), j >= 40, j == 40);
            else n_pass++;
        end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (otx[k*4+2] !== seq[k])
                $display("FAIL basic_slot%0d: got %b required %b", k, otx[k*4+2], seq[k]);
            else n_pass++;
        end
    endtask

    task automatic test_parity();
        logic [7:0] bytes [4];
        logic       pexp;
        int         d;
        for (int c = 0; c < 6; c++) begin
            d = (c < 3) ? 1 : 2;
            bytes[0] = 8'hA5; bytes[1] = 8'h01;
            bytes[2] = 8'($urandom); bytes[3] = 8'($urandom);
            capture(d, bytes[c % 3 == 2 ? 2 : c % 3], 46, -1, -1, 1'b0, 8'h00);
            for (int j = 0; j < 46; j++) begin
                n_checks++;
                if (otx[j] !== exp_tx(j, bytes[c % 3 == 2 ? 2 : c % 3], 4, 1, d - 1) ||
                    oav[j] !== (j >= 44) || odn[j] !== (j == 44))
                    $display("FAIL parity_frame dut%0d case%0d j=%0d: got tx/avail/done=%b%b%b required %b%b%b",
                             d, c, j, otx[j], oav[j], odn[j],
                             exp_tx(j, bytes[c % 3 == 2 ? 2 : c % 3], 4, 1, d - 1), j >= 44, j == 44);
                else n_pass++;
            end
            if (c % 3 != 2) begin
                // hand-derived parity bits: A5 even=0, A5 odd=1, 01 even=1, 01 odd=0
                pexp = (c == 0) ? 1'b0 : (c == 1) ? 1'b1 : (c == 3) ? 1'b1 : 1'b0;
                n_checks++;
                if (otx[9*4+1] !== pexp)
                    $display("FAIL parity_bit dut%0d case%0d: got %b required %b", d, c, otx[9*4+1], pexp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_busy();
        int ndone;
        ndone = 0;
        capture(0, 8'h3C, 50, 5, 20, 1'b0, 8'h00);
        for (int j = 0; j < 50; j++) begin
            if (odn[j] === 1'b1) ndone++;
            n_checks++;
            if (otx[j] !== exp_tx(j, 8'h3C, 4, 0, 0) || oav[j] !== (j >= 40))
                $display("FAIL busy_frame j=%0d: got tx/avail=%b%b required %b%b", j,
                         otx[j], oav[j], exp_tx(j, 8'h3C, 4, 0, 0), j >= 40);
            else n_pass++;
        end
        n_checks++;
        if (ndone !== 1) $display("FAIL busy_done_count: got %0d required 1", ndone);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         r;
        logic [7:0] bb;
        capture(0, 8'h11, 82, -1, -1, 1'b1, 8'h22);
        for (int j = 0; j < 82; j++) begin
            r  = j % 41;
            bb = (j < 41) ? 8'h11 : 8'h22;
            n_checks++;
            if (otx[j] !== exp_tx(r, bb, 4, 0, 0) || oav[j] !== (r == 40) || odn[j] !== (r == 40))
                $display("FAIL b2b_frame j=%0d: got tx/avail/done=%b%b%b required %b%b%b", j,
                         otx[j], oav[j], odn[j], exp_tx(r, bb, 4, 0, 0), r == 40, r == 40);
            else n_pass++;
        end
        n_checks++;
        if ({otx[40], otx[41]} !== 2'b10)
            $display("FAIL b2b_gap: got idle/start=%b%b required 10", otx[40], otx[41]);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if ({tx_v[0], av_v[0], dn_v[0]} !== 3'b110)
            $display("FAIL b2b_release: got tx/avail/done=%b required 110", {tx_v[0], av_v[0], dn_v[0]});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        send_v[0] = 1'b1;
        data_in   = 8'h00;
        for (int j = 0; j < 10; j++) begin
            @(posedge clock); #1;
            send_v[0] = 1'b0;
            data_in   = 8'($urandom);
            n_checks++;
            if ({tx_v[0], av_v[0]} !== 2'b00)
                $display("FAIL midreset_pre j=%0d: got tx/avail=%b required 00", j, {tx_v[0], av_v[0]});
            else n_pass++;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++;
        if ({tx_v[0], av_v[0], dn_v[0]} !== 3'b110)
            $display("FAIL midreset_abort: got tx/avail/done=%b required 110", {tx_v[0], av_v[0], dn_v[0]});
        else n_pass++;
        capture(0, 8'h55, 42, -1, -1, 1'b0, 8'h00);
        for (int j = 0; j < 42; j++) begin
            n_checks++;
            if (otx[j] !== exp_tx(j, 8'h55, 4, 0, 0) || oav[j] !== (j >= 40) || odn[j] !== (j == 40))
                $display("FAIL midreset_frame j=%0d: got tx/avail/done=%b%b%b required %b%b%b", j,
                         otx[j], oav[j], odn[j], exp_tx(j, 8'h55, 4, 0, 0), j >= 40, j == 40);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int c = 0; c < 4; c++) begin
            b = 8'($urandom);
            capture(0, b, 42, -1, -1, 1'b0, 8'h00);
            for (int j = 0; j < 42; j++) begin
                n_checks++;
                if (otx[j] !== exp_tx(j, b, 4, 0, 0) || oav[j] !== (j >= 40) || odn[j] !== (j == 40))
                    $display("FAIL random_frame byte=%h j=%0d: got tx/avail/done=%b%b%b required %b%b%b", b, j,
                             otx[j], oav[j], odn[j], exp_tx(j, b, 4, 0, 0), j >= 40, j == 40);
                else n_pass++;
            end
        end
    endtask

    task automatic test_default();
        capture(3, 8'hFF, 4342, -1, -1, 1'b0, 8'h00);
        for (int j = 0; j < 4342; j++) begin
            n_checks++;
            if (otx[j] !== exp_tx(j, 8'hFF, 434, 0, 0) || oav[j] !== (j >= 4340) || odn[j] !== (j == 4340))
                $display("FAIL default_frame j=%0d: got tx/avail/done=%b%b%b required %b%b%b", j,
                         otx[j], oav[j], odn[j], exp_tx(j, 8'hFF, 434, 0, 0), j >= 4340, j == 4340);
            else n_pass++;
        end
        n_checks++;
        if ({otx[433], otx[434]} !== 2'b01)
            $display("FAIL default_start_len: got tx[433]/tx[434]=%b%b required 01", otx[433], otx[434]);
        else n_pass++;
        for (int j = 0; j < 20; j++) begin
            @(posedge clock); #1;
            n_checks++;
            if ({tx_v[3], av_v[3]} !== 2'b11)
                $display("FAIL default_idle j=%0d: got tx/avail=%b required 11", j, {tx_v[3], av_v[3]});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_default();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
